// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: MIPS load/store opcodes,
// FSM state encoding and opcode classification helpers.
package dm_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dm_state_e;

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte/half/word lane selection, load extension and store byte-merge.
// Misaligned half/word accesses become errors when DM_MISALIGN_TRAP_EN is defined.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word,
    output logic        err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        misalign;

    always_comb begin
        byte_sel = mem_word[{addr_lo, 3'b000} +: 8];
        half_sel = mem_word[{addr_lo[1], 4'b0000} +: 16];
`ifdef DM_MISALIGN_TRAP_EN
        misalign = (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && addr_lo[0]) ||
                   (((op == OP_LW) || (op == OP_SW)) && (addr_lo != 2'b00));
`else
        misalign = 1'b0;
`endif
        err     = !(is_load(op) || is_store(op)) || misalign;
        ld_data = '0;
        st_word = mem_word;
        // Errored requests leave the word untouched and return zero.
        if (!err) begin
            case (op)
                OP_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
                OP_LBU:  ld_data = {24'd0, byte_sel};
                OP_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
                OP_LHU:  ld_data = {16'd0, half_sel};
                OP_LW:   ld_data = mem_word;
                OP_SB:   st_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
                OP_SH:   st_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
                OP_SW:   st_word = wdata;
                default: ld_data = '0;
            endcase
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder for the MEM stage: one request at a time,
// fixed LATENCY, one-cycle response pulse. Optional macro: DM_MISALIGN_TRAP_EN.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);

    localparam int         ADDR_W   = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LAST = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    dm_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [5:0]  acc_op;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [31:0] mem_word;
    logic [31:0] ld_data;
    logic [31:0] st_word;
    logic        lane_err;
    logic        mem_we;
    logic        unused_addr_hi;

    logic [31:0] mem [DEPTH_WORDS];

    // With LATENCY=1 the access happens while still in IDLE, straight off the request.
    assign acc_op    = (state_q == IDLE) ? req_op    : op_q;
    assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign mem_word  = mem[acc_addr[ADDR_W+1:2]];
    assign unused_addr_hi = ^acc_addr[31:ADDR_W+2];

    dm_lane_align u_align (
        .op       (acc_op),
        .addr_lo  (acc_addr[1:0]),
        .mem_word (mem_word),
        .wdata    (acc_wdata),
        .ld_data  (ld_data),
        .st_word  (st_word),
        .err      (lane_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 4'd0;
                    if (LATENCY == 1) begin
                        rdata_d = ld_data;
                        err_d   = lane_err;
                        mem_we  = is_store(acc_op) && !lane_err;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    rdata_d = ld_data;
                    err_d   = lane_err;
                    mem_we  = is_store(acc_op) && !lane_err;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is not reset; reset held low blocks any commit on that edge.
    always_ff @(posedge clk) begin
        if (mem_we && reset) mem[acc_addr[ADDR_W+1:2]] <= st_word;
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign stall     = ((state_q == IDLE) && req_valid) || (state_q == WAIT);

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed lane/extension/error/reset cases
// plus randomized traffic against an arithmetic memory model.
module tb_dm_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
    localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem_m [DEPTH];

    dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Reference model: word-indexed array, lanes by shift/mask arithmetic.
    task automatic model(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic e);
        int unsigned idx = (addr / 4) % DEPTH;
        int unsigned w   = mem_m[idx];
        int unsigned sh  = 8 * (addr % 4);
        int unsigned hs  = 16 * ((addr / 2) % 2);
        int unsigned v;
        logic bad = 1'b0;
`ifdef DM_MISALIGN_TRAP_EN
        if (op == LH || op == LHU || op == SH) bad = (addr % 2) != 0;
        if (op == LW || op == SW) bad = (addr % 4) != 0;
`endif
        rd = 0;
        e  = 1'b0;
        if (bad) e = 1'b1;
        else begin
            case (op)
                LB:  begin v = (w >> sh) % 256;   rd = (v >= 128)   ? v - 256   : v; end
                LBU: rd = (w >> sh) % 256;
                LH:  begin v = (w >> hs) % 65536; rd = (v >= 32768) ? v - 65536 : v; end
                LHU: rd = (w >> hs) % 65536;
                LW:  rd = w;
                SB:  mem_m[idx] = (w & ~(32'hFF << sh)) | ((wd % 256) << sh);
                SH:  mem_m[idx] = (w & ~(32'hFFFF << hs)) | ((wd % 65536) << hs);
                SW:  mem_m[idx] = wd;
                default: e = 1'b1;
            endcase
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge back in IDLE.
    task automatic xact(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e);
        logic [31:0] exp_rd;
        logic        exp_e;
        int k = 0;
        int nstall;
        model(op, addr, wd, exp_rd, exp_e);
        req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        #1;
        chk("ready", 32'(req_ready), 1);
        nstall = int'(stall);
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (rsp_valid) break;
            nstall += int'(stall);
        end
        chk("latency", k, LAT);
        chk("stall_cnt", nstall, LAT);
        chk("stall_resp", 32'(stall), 0);
        chk("rdata", rsp_rdata, exp_rd);
        chk("err", 32'(rsp_err), 32'(exp_e));
        rd = rsp_rdata;
        e  = rsp_err;
        @(negedge clk);
        chk("pulse", 32'(rsp_valid), 0);
        chk("hold", rsp_rdata, exp_rd);
    endtask

    logic [5:0] ops [10] = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 6'h00, 6'h3F};

    initial begin
        logic [31:0] rd;
        logic        e;
        int          seen;
        int          cyc;
        int          times[$];
        logic [31:0] a;

        reset = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err",   32'(rsp_err), 0);
        chk("rst_stall", 32'(stall), 0);
        reset = 1'b1;

        for (int i = 0; i < 32; i++) xact(SW, 32'(i * 4), $urandom, rd, e);

        xact(SW, 32'h10, 32'h11223344, rd, e);
        xact(LW, 32'h10, 0, rd, e);           chk("lw10", rd, 32'h11223344);

        xact(SW, 32'h20, 32'h80FF7F01, rd, e);
        xact(LB,  32'h21, 0, rd, e);          chk("lb21",  rd, 32'h0000007F);
        xact(LB,  32'h22, 0, rd, e);          chk("lb22",  rd, 32'hFFFFFFFF);
        xact(LBU, 32'h23, 0, rd, e);          chk("lbu23", rd, 32'h00000080);
        xact(LH,  32'h22, 0, rd, e);          chk("lh22",  rd, 32'hFFFF80FF);
        xact(LHU, 32'h22, 0, rd, e);          chk("lhu22", rd, 32'h000080FF);

        xact(SW, 32'h30, 32'hAABBCCDD, rd, e);
        xact(SB, 32'h31, 32'h12, rd, e);
        xact(LW, 32'h30, 0, rd, e);           chk("sb31", rd, 32'hAABB12DD);
        xact(SH, 32'h32, 32'h5678, rd, e);
        xact(LW, 32'h30, 0, rd, e);           chk("sh32", rd, 32'h567812DD);

        xact(SW, 32'h40, 32'hCAFEF00D, rd, e);
        xact(6'h00, 32'h40, 32'hFFFFFFFF, rd, e);
        chk("badop_err", 32'(e), 1);
        chk("badop_rd", rd, 0);
        xact(LW, 32'h40, 0, rd, e);           chk("badop_mem", rd, 32'hCAFEF00D);
        xact(LW, 32'h41, 0, rd, e);
`ifdef DM_MISALIGN_TRAP_EN
        chk("lw41_err", 32'(e), 1);
        chk("lw41_rd", rd, 0);
`else
        chk("lw41_err", 32'(e), 0);
        chk("lw41_rd", rd, 32'hCAFEF00D);
`endif

        // Reset in WAIT drops the pending store.
        xact(SW, 32'h50, 32'h0BADBEEF, rd, e);
        req_op = SW; req_addr = 32'h50; req_wdata = 32'h12345678; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("wrst_ready", 32'(req_ready), 1);
        chk("wrst_valid", 32'(rsp_valid), 0);
        #1 reset = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            seen += int'(rsp_valid);
        end
        chk("wrst_norsp", seen, 0);
        xact(LW, 32'h50, 0, rd, e);           chk("wrst_mem", rd, 32'h0BADBEEF);

        xact(SW, 32'(4 * DEPTH + 8), 32'h13572468, rd, e);
        xact(LW, 32'h8, 0, rd, e);            chk("alias", rd, 32'h13572468);

        // Held req_valid: acceptances spaced LAT+1 apart.
        req_op = LW; req_addr = 32'h8; req_valid = 1'b1;
        cyc = 0;
        while (times.size() < 3 && cyc < 40) begin
            if (req_ready) times.push_back(cyc);
            if (times.size() < 3) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("b2b_count", times.size(), 3);
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        if (times.size() == 3) begin
            chk("b2b_gap0", times[1] - times[0], LAT + 1);
            chk("b2b_gap1", times[2] - times[1], LAT + 1);
        end

        for (int i = 0; i < 80; i++) begin
            a = ($urandom & ~32'(4 * DEPTH - 1)) |
                32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            xact(ops[$urandom_range(0, 9)], a, $urandom, rd, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Multi-cycle data-memory responder: the memory-side end of the MEM-stage load/store interface.
- Accepts one request at a time from the pipeline's MEM stage and performs the access after a fixed latency.
- Returns a one-cycle response and holds the pipeline with `stall` until that response arrives.
- Decodes MIPS load/store opcodes to do byte, half and word lane selection, sign/zero extension and byte-merged stores.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words. Power of two. ADDR_W = log2(DEPTH_WORDS).
- LATENCY, 2: cycles from request acceptance to `rsp_valid`. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage presents a request.
- req_ready  out  1  responder can accept a request.
- req_op  in  6  instruction opcode field [31:26].
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (forwarded rt value).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request was illegal (unknown opcode, or misaligned when checking is enabled).
- stall  out  1  freeze IF/ID/EX/MEM pipeline registers.

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, stall=0, FSM in IDLE. Memory array is not reset.
- Opcodes:
  - Loads: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25.
  - Stores: SB 0x28, SH 0x29, SW 0x2B.
  - Any other opcode: error, no write, rsp_rdata=0.
- Word index = req_addr[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo the memory size.
- Byte lanes are little-endian: addr[1:0]=0 selects bits 7:0. Half lane is selected by addr[1]: 0 selects bits 15:0.
- FSM states:
  - IDLE: req_ready=1. When req_valid=1 at an edge, capture op, addr and wdata. Go to WAIT, or straight to RESP if LATENCY=1.
  - WAIT: a 4-bit counter counts LATENCY-1 cycles. On the last WAIT edge, read the addressed word and commit a store (read-modify-write byte merge). The extended read data and the error flag are registered, and the FSM enters RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then back to IDLE. req_ready=0.
  - LATENCY=1: the memory access happens on the edge leaving IDLE and the FSM goes directly to RESP.
- Latency: request accepted at edge N gives rsp_valid high during the cycle after edge N+LATENCY-1. Total LATENCY cycles.
- stall = (state==IDLE & req_valid) | (state==WAIT). stall is 0 in RESP, so the pipeline advances on the same edge that consumes the response.
- req_valid held high in RESP is not accepted. The FSM returns to IDLE first, so back-to-back requests are separated by one bubble cycle.
- rsp_rdata and rsp_err hold their values after RESP until the next response. Consumers must qualify them with rsp_valid.
- Store data is taken from the captured wdata:
  - SB writes wdata[7:0] into the selected byte lane.
  - SH writes wdata[15:0] into the selected half lane.
  - SW writes the full word.
- Reset asserted in WAIT: FSM returns to IDLE and any uncommitted store is dropped. Reset asserted in RESP: the store is already committed.

Optional Feature:
- Macro DM_MISALIGN_TRAP_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1 is an error.
  - LW/SW with addr[1:0]≠0 is an error.
  - On error: rsp_err=1, no write, rsp_rdata=0.
- Undefined: misaligned low address bits are ignored for the lane granularity. Half accesses use addr[1]; word accesses force [1:0]=0.

Decomposition:
- Shared package dm_pkg:
  - Opcode localparams (OP_LB … OP_SW).
  - FSM state enum {IDLE, WAIT, RESP}.
  - Function is_store(op).
- Sub-module dm_lane_align (combinational):
  - Inputs: op, addr[1:0], memory word, wdata.
  - Outputs: extended load data, merged store word, error flag.
- The FSM, counter and memory array stay in dm_responder.

Test Plan:
- SW 0x11223344 to addr 0x10 (LATENCY=2), then LW addr 0x10 → each response arrives 2 cycles after acceptance; LW rsp_rdata=0x11223344; stall high for 2 cycles per access.
- Word at 0x20 = 0x80FF7F01:
  - LB addr 0x21 → 0x0000007F.
  - LB addr 0x22 → 0xFFFFFFFF.
  - LBU addr 0x23 → 0x00000080.
  - LH addr 0x22 → 0xFFFF80FF.
  - LHU addr 0x22 → 0x000080FF.
- Word at 0x30 = 0xAABBCCDD:
  - SB 0x31 with wdata 0x12 → word becomes 0xAABB12DD.
  - SH 0x32 with wdata 0x5678 → word becomes 0x567812DD.
- req_op=0x00 at addr 0x40 → rsp_err=1, rsp_rdata=0, memory unchanged. With DM_MISALIGN_TRAP_EN, LW addr 0x41 → rsp_err=1.
- Reset pulsed low in WAIT of SW addr 0x50 (LATENCY=4) → no rsp_valid, word at 0x50 unchanged, req_ready=1 immediately.
- req_valid held high for 3 requests → acceptances exactly LATENCY+1 cycles apart. Address 4*DEPTH_WORDS+8 aliases to word 2.
